ysyx_22050039_core: RTL and testbench

Single-cycle RV64I integer core slice built from three units: IFU (PC register), IDU (decoder plus register file), EXU (ALU and next-PC adder). It executes the OP-IMM instruction group and EBREAK. The PC goes out to an external instruction memory, which returns the fetched word combinationally on `inst` in the same cycle.

---
 rtl/ysyx_22050039_pkg.sv | 30 +++
 rtl/ysyx_22050039_EXU.sv | 37 +++
 rtl/ysyx_22050039_IDU.sv | 60 ++++++
 rtl/ysyx_22050039_IFU.sv | 27 ++
 rtl/ysyx_22050039_RegisterFile.sv | 33 +++
 rtl/ysyx_22050039_core.sv | 56 +++++
 tb/tb_ysyx_22050039_core.sv | 251 +++++++++++++++++++++++++
 7 files changed

// File: rtl/ysyx_22050039_pkg.sv
// Shared constants and decode helpers for the ysyx_22050039 core slice.
package ysyx_22050039_pkg;

    localparam logic [6:0]  OPCODE_OP_IMM = 7'b0010011;
    localparam logic [31:0] INST_EBREAK   = 32'h0010_0073;
    localparam logic [63:0] RESET_PC      = 64'h0000_0000_8000_0000;

    localparam logic [2:0] FUNC_ADD  = 3'b000;
    localparam logic [2:0] FUNC_SLT  = 3'b010;
    localparam logic [2:0] FUNC_SLTU = 3'b011;
    localparam logic [2:0] FUNC_XOR  = 3'b100;
    localparam logic [2:0] FUNC_OR   = 3'b110;
    localparam logic [2:0] FUNC_AND  = 3'b111;

    // I-type instruction layout, MSB first.
    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } inst_i_t;

    // Shifts (001/101) are not supported, so they count as illegal.
    function automatic logic is_supported_func(input logic [2:0] f);
        return (f == FUNC_ADD) || (f == FUNC_SLT) || (f == FUNC_SLTU) ||
               (f == FUNC_XOR) || (f == FUNC_OR)  || (f == FUNC_AND);
    endfunction

endpackage

// File: rtl/ysyx_22050039_EXU.sv
// Execute unit: OP-IMM ALU and sequential next-PC adder, purely combinational.
module ysyx_22050039_EXU
    import ysyx_22050039_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2:0]      func,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] exec_result,
    output logic [XLEN-1:0] dnpc
);

    // Clock and reset are part of the unit's port contract but carry no state here.
    logic clk_rst_unused;
    assign clk_rst_unused = clk ^ rst;

    // ALU result select.
    always_comb begin
        exec_result = '0;
        case (func)
            FUNC_ADD:  exec_result = src1 + src2;
            FUNC_SLT:  exec_result = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
            FUNC_SLTU: exec_result = {{(XLEN-1){1'b0}}, (src1 < src2)};
            FUNC_XOR:  exec_result = src1 ^ src2;
            FUNC_OR:   exec_result = src1 | src2;
            FUNC_AND:  exec_result = src1 & src2;
            default:   exec_result = '0;
        endcase
    end

    assign dnpc = pc + XLEN'(4);

endmodule

// File: rtl/ysyx_22050039_IDU.sv
// Instruction decode unit: field extraction, register file, legality and halt control.
module ysyx_22050039_IDU
    import ysyx_22050039_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INST_LEN-1:0] inst,
    input  logic [XLEN-1:0]     exec_result,
    output logic [XLEN-1:0]     src1,
    output logic [XLEN-1:0]     src2,
    output logic [2:0]          func,
    output logic                pc_wen
);

    inst_i_t         fields;
    logic            is_op_imm;
    logic            legal_op_imm;
    logic            is_ebreak;
    logic            stop;
    logic            halted_q;
    logic [XLEN-1:0] rdata2_unused;

    assign fields       = inst_i_t'(inst[31:0]);
    assign is_op_imm    = (fields.opcode == OPCODE_OP_IMM);
    assign legal_op_imm = is_op_imm && is_supported_func(fields.funct3);
    assign is_ebreak    = (inst[31:0] == INST_EBREAK);
    // EBREAK is not OP-IMM, so this covers both EBREAK and every illegal word.
    assign stop         = is_ebreak || !legal_op_imm;

    assign src2   = {{(XLEN-12){fields.imm[11]}}, fields.imm};
    assign func   = is_op_imm ? fields.funct3 : FUNC_ADD;
    assign pc_wen = !halted_q && legal_op_imm;

    // Sticky halt flag; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else if (stop) begin
            halted_q <= 1'b1;
        end
    end

    ysyx_22050039_RegisterFile #(
        .XLEN(XLEN)
    ) regs (
        .clk   (clk),
        .rst   (rst),
        .raddr1(fields.rs1),
        .raddr2(inst[24:20]),
        .rdata1(src1),
        .rdata2(rdata2_unused),
        .wen   (pc_wen),
        .waddr (fields.rd),
        .wdata (exec_result)
    );

endmodule

// File: rtl/ysyx_22050039_IFU.sv
// Instruction fetch unit: holds the program counter.
module ysyx_22050039_IFU
    import ysyx_22050039_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_wen,
    input  logic [XLEN-1:0] pc_wdata,
    output logic [XLEN-1:0] pc
);

    logic [XLEN-1:0] pc_q;

    // PC register; holds unless the current instruction retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC[XLEN-1:0];
        end else if (pc_wen) begin
            pc_q <= pc_wdata;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ysyx_22050039_RegisterFile.sv
// 32-entry integer register file, 2 read ports and 1 write port; x0 hardwired to zero.
module ysyx_22050039_RegisterFile #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            wen,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] rf [32];

    // Storage; reset clears every entry, x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wen && (waddr != 5'd0)) begin
            rf[waddr] <= wdata;
        end
    end

    // Asynchronous reads return the pre-edge value on a same-cycle write.
    assign rdata1 = (raddr1 == 5'd0) ? '0 : rf[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : rf[raddr2];

endmodule

// File: rtl/ysyx_22050039_core.sv
// Single-cycle RV64I OP-IMM/EBREAK core: IFU -> IDU -> EXU, writeback and PC on one edge.
module ysyx_22050039_core #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INST_LEN-1:0] inst,
    output logic [XLEN-1:0]     pc
);

    logic            pc_wen;
    logic [XLEN-1:0] dnpc;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [2:0]      func;
    logic [XLEN-1:0] exec_result;

    ysyx_22050039_IFU #(
        .XLEN(XLEN)
    ) u_ifu (
        .clk     (clk),
        .rst     (rst),
        .pc_wen  (pc_wen),
        .pc_wdata(dnpc),
        .pc      (pc)
    );

    ysyx_22050039_IDU #(
        .XLEN    (XLEN),
        .INST_LEN(INST_LEN)
    ) u_idu (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .exec_result(exec_result),
        .src1       (src1),
        .src2       (src2),
        .func       (func),
        .pc_wen     (pc_wen)
    );

    ysyx_22050039_EXU #(
        .XLEN(XLEN)
    ) u_exu (
        .clk        (clk),
        .rst        (rst),
        .func       (func),
        .src1       (src1),
        .src2       (src2),
        .pc         (pc),
        .exec_result(exec_result),
        .dnpc       (dnpc)
    );

endmodule

// File: tb/tb_ysyx_22050039_core.sv
// Directed self-checking bench for ysyx_22050039_core.
module tb_ysyx_22050039_core;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBRK   = 32'h0010_0073;
    localparam logic [31:0] SLLI   = 32'h0010_9093;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst = NOP;
    logic [63:0] pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22050039_core dut (
        .clk (clk),
        .rst (rst),
        .inst(inst),
        .pc  (pc)
    );

    function automatic logic [31:0] enc(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Present an instruction for one cycle; returns 1 time unit after the edge.
    task automatic exec(input logic [31:0] i);
        inst = i;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset;
        inst = NOP;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        logic bad;
        inst = NOP;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (pc !== RST_PC) begin
            errors++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC);
        end
        rst = 1'b0;
        exec(NOP);
        checks++;
        if (pc !== 64'h8000_0004) begin
            errors++; $display("FAIL nop_pc1: got %h want %h", pc, 64'h8000_0004);
        end
        exec(NOP);
        checks++;
        if (pc !== 64'h8000_0008) begin
            errors++; $display("FAIL nop_pc2: got %h want %h", pc, 64'h8000_0008);
        end
        exec(enc(12'd9, 5'd0, 3'b000, 5'd5));
        checks++;
        if (dut.u_idu.regs.rf[5] !== 64'd9) begin
            errors++; $display("FAIL pre_reset_x5: got %h want %h", dut.u_idu.regs.rf[5], 64'd9);
        end
        // Asynchronous reset mid-cycle.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (pc !== RST_PC) begin
            errors++; $display("FAIL midreset_pc: got %h want %h", pc, RST_PC);
        end
        bad = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (dut.u_idu.regs.rf[i] !== 64'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL midreset_regs: got nonzero x5=%h want all 0",
                               dut.u_idu.regs.rf[5]);
        end
        #1 rst = 1'b0;
        exec(NOP);
        checks++;
        if (pc !== 64'h8000_0004) begin
            errors++; $display("FAIL post_reset_pc: got %h want %h", pc, 64'h8000_0004);
        end
    endtask

    task automatic test_addi;
        pulse_reset();
        exec(enc(12'd5, 5'd0, 3'b000, 5'd1));
        checks++;
        if (dut.u_idu.regs.rf[1] !== 64'd5) begin
            errors++; $display("FAIL addi_x1: got %h want %h", dut.u_idu.regs.rf[1], 64'd5);
        end
        exec(enc(12'hFF9, 5'd1, 3'b000, 5'd2));
        checks++;
        if (dut.u_idu.regs.rf[2] !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            errors++; $display("FAIL addi_x2: got %h want %h", dut.u_idu.regs.rf[2],
                               64'hFFFF_FFFF_FFFF_FFFE);
        end
        checks++;
        if (pc !== 64'h8000_0008) begin
            errors++; $display("FAIL addi_pc: got %h want %h", pc, 64'h8000_0008);
        end
    endtask

    task automatic test_slt;
        pulse_reset();
        exec(enc(12'hFFF, 5'd0, 3'b000, 5'd1));
        exec(enc(12'd7, 5'd0, 3'b000, 5'd4));
        exec(enc(12'd0, 5'd1, 3'b010, 5'd3));
        checks++;
        if (dut.u_idu.regs.rf[3] !== 64'd1) begin
            errors++; $display("FAIL slti_x3: got %h want %h", dut.u_idu.regs.rf[3], 64'd1);
        end
        exec(enc(12'd1, 5'd1, 3'b011, 5'd4));
        checks++;
        if (dut.u_idu.regs.rf[4] !== 64'd0) begin
            errors++; $display("FAIL sltiu_x4: got %h want %h", dut.u_idu.regs.rf[4], 64'd0);
        end
        exec(enc(12'd1, 5'd0, 3'b011, 5'd8));
        checks++;
        if (dut.u_idu.regs.rf[8] !== 64'd1) begin
            errors++; $display("FAIL sltiu_x8: got %h want %h", dut.u_idu.regs.rf[8], 64'd1);
        end
    endtask

    task automatic test_logic;
        pulse_reset();
        exec(enc(12'h0F0, 5'd0, 3'b000, 5'd1));
        exec(enc(12'h0FF, 5'd1, 3'b100, 5'd5));
        checks++;
        if (dut.u_idu.regs.rf[5] !== 64'h00F) begin
            errors++; $display("FAIL xori: got %h want %h", dut.u_idu.regs.rf[5], 64'h00F);
        end
        exec(enc(12'h00F, 5'd1, 3'b110, 5'd6));
        checks++;
        if (dut.u_idu.regs.rf[6] !== 64'h0FF) begin
            errors++; $display("FAIL ori: got %h want %h", dut.u_idu.regs.rf[6], 64'h0FF);
        end
        exec(enc(12'h030, 5'd1, 3'b111, 5'd7));
        checks++;
        if (dut.u_idu.regs.rf[7] !== 64'h030) begin
            errors++; $display("FAIL andi: got %h want %h", dut.u_idu.regs.rf[7], 64'h030);
        end
        exec(enc(12'd1, 5'd1, 3'b000, 5'd0));
        checks++;
        if (dut.u_idu.regs.rf[0] !== 64'd0) begin
            errors++; $display("FAIL x0_write: got %h want %h", dut.u_idu.regs.rf[0], 64'd0);
        end
        checks++;
        if (pc !== 64'h8000_0014) begin
            errors++; $display("FAIL logic_pc: got %h want %h", pc, 64'h8000_0014);
        end
    endtask

    task automatic test_ebreak;
        pulse_reset();
        exec(enc(12'd3, 5'd0, 3'b000, 5'd1));
        exec(NOP);
        exec(NOP);
        exec(NOP);
        checks++;
        if (pc !== 64'h8000_0010) begin
            errors++; $display("FAIL ebreak_setup_pc: got %h want %h", pc, 64'h8000_0010);
        end
        exec(EBRK);
        checks++;
        if (pc !== 64'h8000_0010) begin
            errors++; $display("FAIL ebreak_pc: got %h want %h", pc, 64'h8000_0010);
        end
        for (int i = 0; i < 10; i++) begin
            exec(enc(12'd1, 5'd1, 3'b000, 5'd1));
            checks++;
            if (pc !== 64'h8000_0010) begin
                errors++; $display("FAIL halted_pc[%0d]: got %h want %h", i, pc, 64'h8000_0010);
            end
        end
        checks++;
        if (dut.u_idu.regs.rf[1] !== 64'd3) begin
            errors++; $display("FAIL halted_x1: got %h want %h", dut.u_idu.regs.rf[1], 64'd3);
        end
        pulse_reset();
        checks++;
        if (pc !== RST_PC) begin
            errors++; $display("FAIL restart_pc: got %h want %h", pc, RST_PC);
        end
        exec(NOP);
        checks++;
        if (pc !== 64'h8000_0004) begin
            errors++; $display("FAIL restart_run: got %h want %h", pc, 64'h8000_0004);
        end
    endtask

    task automatic test_illegal;
        pulse_reset();
        exec(enc(12'd3, 5'd0, 3'b000, 5'd1));
        exec(SLLI);
        checks++;
        if (pc !== 64'h8000_0004) begin
            errors++; $display("FAIL slli_pc: got %h want %h", pc, 64'h8000_0004);
        end
        checks++;
        if (dut.u_idu.regs.rf[1] !== 64'd3) begin
            errors++; $display("FAIL slli_x1: got %h want %h", dut.u_idu.regs.rf[1], 64'd3);
        end
        exec(enc(12'd1, 5'd1, 3'b000, 5'd1));
        checks++;
        if (pc !== 64'h8000_0004 || dut.u_idu.regs.rf[1] !== 64'd3) begin
            errors++; $display("FAIL illegal_frozen: got pc=%h x1=%h want pc=%h x1=%h",
                               pc, dut.u_idu.regs.rf[1], 64'h8000_0004, 64'd3);
        end
    endtask

    task automatic test_wrap;
        inst = NOP;
        rst  = 1'b1;
        force dut.pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        checks++;
        if (dut.dnpc !== 64'd0) begin
            errors++; $display("FAIL dnpc_wrap: got %h want %h", dut.dnpc, 64'd0);
        end
        release dut.pc;
        #1;
        checks++;
        if (pc !== RST_PC) begin
            errors++; $display("FAIL wrap_release_pc: got %h want %h", pc, RST_PC);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_slt();
        test_logic();
        test_ebreak();
        test_illegal();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
